// File: rtl/uart_rx_multibyte.sv
// uart_rx_multibyte: UART receiver that assembles DATA_BYTE consecutive
// characters (start, 8 data bits LSB first, STOP_BITS stop bits) into one
// wide word. Byte 0 lands in bits [7:0].
// Optional feature macro: UART_PARITY_EN adds one parity bit per character
// after the data bits. The parity sense comes from PARITY_ODD.
module uart_rx_multibyte #(
    parameter int DATA_BYTE    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int TIMEOUT_BITS = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   rxEn,
    input  logic                   uart_rx_sended_data_bit,
    output logic                   rxDone,
    output logic                   rxBusy,
    output logic                   rxError,
    output logic [DATA_BYTE*8-1:0] uart_rx_taken_data
);
    localparam int CW = $clog2(CLKS_PER_BIT * TIMEOUT_BITS + 1);
    localparam int BW = (DATA_BYTE > 1) ? $clog2(DATA_BYTE) : 1;
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] TMO_M1    = CW'(CLKS_PER_BIT * TIMEOUT_BITS - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(DATA_BYTE - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_START,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q, prev_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [BW-1:0]          byte_q, byte_d;
    logic [7:0]             shift_q, shift_d;
    logic [DATA_BYTE*8-1:0] asm_q, asm_d;
    logic [DATA_BYTE*8-1:0] data_q, data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   busy_q;
    logic                   perr_q, perr_d;
    logic                   par_bad;
    logic                   rx;
    logic                   fall;

    assign rx   = sync2_q;
    assign fall = prev_q & ~sync2_q;

`ifdef UART_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    assign par_bad = perr_q;
`else
    // Parity sense has no meaning without the parity bit.
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
    assign par_bad = 1'b0;
`endif

    // Next-state logic: bit timing, sampling, byte assembly and status pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        asm_d   = asm_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        perr_d  = perr_q;
        if (!rxEn) begin
            // Silent abort: no pulse, last good word untouched.
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_d = START;
                        cnt_d   = '0;
                        byte_d  = '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d = '0;
                        bit_d = '0;
                        if (rx) begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            state_d = (byte_q != '0) ? WAIT_START : IDLE;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        shift_d = {rx, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            bit_d = '0;
`ifdef UART_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        state_d = STOP;
                        if (rx != (^shift_q ^ PAR_ODD)) begin
                            perr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d = '0;
                        if (!rx) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                            bit_d   = '0;
                        end else if (bit_q == LAST_STOP) begin
                            bit_d = '0;
                            if (par_bad) begin
                                err_d   = 1'b1;
                                state_d = IDLE;
                            end else begin
                                asm_d[int'(byte_q)*8 +: 8] = shift_q;
                                if (byte_q == LAST_BYTE) begin
                                    state_d = DONE;
                                    done_d  = 1'b1;
                                    data_d  = asm_d;
                                end else begin
                                    byte_d  = byte_q + 1'b1;
                                    state_d = WAIT_START;
                                end
                            end
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_START: begin
                    if (fall) begin
                        state_d = START;
                        cnt_d   = '0;
                    end else if (cnt_q == TMO_M1) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        if (state_d == IDLE) begin
            perr_d = 1'b0;
        end
    end

    // State, synchroniser and datapath registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= uart_rx_sended_data_bit;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
            perr_q  <= perr_d;
        end
    end

    assign rxDone             = done_q;
    assign rxError            = err_q;
    assign rxBusy             = busy_q;
    assign uart_rx_taken_data = data_q;
endmodule

// File: doc/uart_rx_multibyte.md
Name:
uart_rx_multibyte

Overview:
Parametrised UART receiver and the successor of the single-byte RX path. It deserialises DATA_BYTE consecutive 8N1/8N2 characters into one wide word, with mid-bit sampling, glitch rejection, framing and inter-byte timeout detection, and optional parity. It sits between the serial RX pin and the block that consumes uart_rx_taken_data. Its status outputs (rxDone, rxBusy, rxError) keep the names already used on the UART interface.

Parameters:
DATA_BYTE, 1, characters per assembled word (>=1); byte 0 lands in bits [7:0].
CLKS_PER_BIT, 16, i_clk cycles per bit period (>=4, even).
STOP_BITS, 1, stop bits per character (1 or 2).
TIMEOUT_BITS, 4, maximum idle bit-times allowed between characters of one word (>=1).
PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only with UART_PARITY_EN.

Ports:
i_clk  in  1  system clock.
i_rst_n  in  1  asynchronous active-low reset.
rxEn  in  1  receive enable (level).
uart_rx_sended_data_bit  in  1  serial RX line, idle high, asynchronous to i_clk.
rxDone  out  1  one-cycle pulse: word valid.
rxBusy  out  1  high while a word is in progress.
rxError  out  1  one-cycle pulse: word discarded.
uart_rx_taken_data  out  DATA_BYTE*8  last good word.

Behaviour:
- Reset: state IDLE; rxDone, rxBusy and rxError = 0; uart_rx_taken_data = 0. Synchroniser flops = 1, counters = 0, shift/assembly registers = 0.
- Input path: 2-flop synchroniser plus a previous-value flop. A falling edge is sync_prev==1 && sync==0. Synchroniser latency is 2 cycles.
- IDLE: if rxEn && falling edge, clear the bit counter, set byte index to 0, go to START.
- START: sample at count CLKS_PER_BIT/2-1.
  - Sample 1: glitch. Return to IDLE (or WAIT_START when byte index > 0). No error.
  - Sample 0: go to DATA.
- DATA: sample every CLKS_PER_BIT cycles from the start-bit mid-point. 8 bits, LSB first. After bit 7, go to PARITY if the macro is defined, else STOP.
- STOP: sample STOP_BITS bits.
  - Any stop bit = 0: framing error. Pulse rxError, discard the word, go to IDLE.
  - Otherwise, write the byte into assembly slot [byte index].
- After a good character:
  - If byte index == DATA_BYTE-1, go to DONE.
  - Otherwise increment byte index and go to WAIT_START.
- WAIT_START: a falling edge goes to START. If no edge arrives within TIMEOUT_BITS*CLKS_PER_BIT cycles, pulse rxError, discard the partial word, go to IDLE.
- DONE: a single cycle. uart_rx_taken_data <= assembly register and rxDone = 1 in that cycle, then IDLE. The data holds until the next DONE.
- Latency: rxDone rises 1 cycle after the mid-point of the last stop bit (registered).
- rxBusy = 1 in every state except IDLE. It is registered and asserts the cycle after the start edge is detected.
- rxEn deasserted in any state: abort next cycle, go to IDLE. No rxDone, no rxError, uart_rx_taken_data unchanged.
- A line stuck low after an error does not retrigger; a new 1->0 edge is required.
- rxDone and rxError are never high in the same cycle.
- Counters saturate/reset explicitly and never wrap. Bit counter width is $clog2(CLKS_PER_BIT*TIMEOUT_BITS+1).
- Asynchronous reset mid-frame: everything clears immediately and no pulse is emitted.

Optional Feature:
UART_PARITY_EN
- Defined:
  - A PARITY state follows DATA; one bit is sampled at mid-bit.
  - Expected parity is ^byte ^ PARITY_ODD.
  - A mismatch sets a sticky error flag. STOP is still received.
  - At the end of STOP with the flag set: rxError pulse, word discarded, IDLE. The flag clears on entry to IDLE.
- Undefined:
  - No PARITY state and no parity logic; PARITY_ODD is ignored.
  - Frame is start + 8 data + STOP_BITS.

Test Plan:
- Reset: DATA_BYTE=2, CLKS_PER_BIT=16. Hold i_rst_n=0 → all outputs 0. Release with line high and rxEn=1 → rxBusy stays 0.
- Basic word: send 0x3C then 0xA5, 8N1, back-to-back → a single rxDone pulse, uart_rx_taken_data=16'hA53C, rxError never 1, rxBusy=0 the cycle after rxDone.
- Glitch and framing:
  - 5-cycle low pulse on idle line → no rxBusy after START, no rxError.
  - Byte with stop bit 0 → rxError pulse, uart_rx_taken_data keeps its previous value 16'hA53C.
- Inter-byte timeout: send 0x11, then hold the line high for 4*16+1 cycles → rxError pulse exactly 64 cycles after WAIT_START entry. A following good 0x22,0x33 gives 16'h3322.
- Abort: drop rxEn during bit 3 of byte 1 → rxBusy=0 within 2 cycles, no rxDone/rxError. Re-enable and send 0x01,0x02 → 16'h0201.
- Parity (UART_PARITY_EN, PARITY_ODD=0): send 0x07 with parity 1 and 0x00 with parity 0 → rxDone, 16'h0007. Repeat with byte 0 parity bit 0 → rxError after STOP, no rxDone.
